// File: rtl/alu_z_stage.sv
// -----------------------------------------------------------------------------
// alu_z_stage
//   Sequencing and result-capture stage around the 5-bit-opcode datapath ALU.
//   Accepts an opcode, holds it on alu_op while the ALU computes, waits the
//   opcode-dependent latency, captures the 64-bit ALU result into ZHi/ZLo,
//   derives zero/negative flags and offers the result on a valid/ready
//   handshake.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   clr        in   1   synchronous active-high reset
//   start      in   1   request a new operation (sampled only when accepting)
//   opcode     in   5   operation code, sampled with an accepted start
//   alu_op     out  5   registered opcode driven to the ALU
//   c_in       in  64   ALU result (C_Register)
//   busy       out  1   high while waiting on the ALU
//   z_valid    out  1   result available on zhi/zlo
//   z_ready    in   1   consumer accepts the result
//   zhi        out 32   captured upper word
//   zlo        out 32   captured lower word
//   zero_flag  out  1   captured result equals zero
//   neg_flag   out  1   captured result is negative
//   op_illegal out  1   captured opcode was not a defined operation
//
// Parameters:
//   MUL_LAT  ALU cycles for MUL (10011), 1..31
//   DIV_LAT  ALU cycles for DIV (10100), 1..63
// -----------------------------------------------------------------------------
module alu_z_stage #(
   parameter int unsigned MUL_LAT = 2,
   parameter int unsigned DIV_LAT = 32
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [4:0]  opcode,
   output logic [4:0]  alu_op,
   input  logic [63:0] c_in,
   output logic        busy,
   output logic        z_valid,
   input  logic        z_ready,
   output logic [31:0] zhi,
   output logic [31:0] zlo,
   output logic        zero_flag,
   output logic        neg_flag,
   output logic        op_illegal
);

   localparam logic [4:0] OP_MUL = 5'b10011;
   localparam logic [4:0] OP_DIV = 5'b10100;

   localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
   localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [4:0]  alu_op_q, alu_op_d;
   logic [31:0] zhi_q, zhi_d;
   logic [31:0] zlo_q, zlo_d;
   logic        zero_q, zero_d;
   logic        neg_q, neg_d;
   logic        ill_q, ill_d;

   logic        accept;
   logic [31:0] cap_hi, cap_lo;
   logic        cap_ill;

   // Counter preload is LAT-1 so that capture lands exactly LAT edges after accept.
   function automatic logic [5:0] lat_m1(input logic [4:0] op);
      if (op == OP_MUL)      return MUL_CNT;
      else if (op == OP_DIV) return DIV_CNT;
      else                   return 6'd0;
   endfunction

   // Defined: 00000-01011 and 01110-10100 (the latter range includes MUL/DIV).
   function automatic logic op_defined(input logic [4:0] op);
      return (op <= 5'd11) || ((op >= 5'd14) && (op <= 5'd20));
   endfunction

   // Result shaping by the opcode currently held on alu_op.
   always_comb begin
      cap_hi  = '0;
      cap_lo  = '0;
      cap_ill = 1'b0;
      if ((alu_op_q == OP_MUL) || (alu_op_q == OP_DIV)) begin
         cap_hi = c_in[63:32];
         cap_lo = c_in[31:0];
      end else if (op_defined(alu_op_q)) begin
         cap_lo = c_in[31:0];
      end else begin
         cap_ill = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      alu_op_d = alu_op_q;
      zhi_d    = zhi_q;
      zlo_d    = zlo_q;
      zero_d   = zero_q;
      neg_d    = neg_q;
      ill_d    = ill_q;
      accept   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) accept = 1'b1;
         end
         ST_WAIT: begin
            if (cnt_q != 6'd0) begin
               cnt_d = cnt_q - 6'd1;
            end else begin
               zhi_d   = cap_hi;
               zlo_d   = cap_lo;
               ill_d   = cap_ill;
               zero_d  = ({cap_hi, cap_lo} == 64'd0);
               neg_d   = (alu_op_q == OP_MUL) ? cap_hi[31] : cap_lo[31];
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Retiring a result and accepting the next op share one edge.
            if (z_ready) begin
               if (start) accept = 1'b1;
               else       state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         alu_op_d = opcode;
         cnt_d    = lat_m1(opcode);
         state_d  = ST_WAIT;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         alu_op_q <= '0;
         zhi_q    <= '0;
         zlo_q    <= '0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         alu_op_q <= alu_op_d;
         zhi_q    <= zhi_d;
         zlo_q    <= zlo_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         ill_q    <= ill_d;
      end
   end

   assign alu_op     = alu_op_q;
   assign busy       = (state_q == ST_WAIT);
   assign z_valid    = (state_q == ST_HOLD);
   assign zhi        = zhi_q;
   assign zlo        = zlo_q;
   assign zero_flag  = zero_q;
   assign neg_flag   = neg_q;
   assign op_illegal = ill_q;

endmodule

// File: tb/tb_alu_z_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_z_stage
//   Directed testbench for alu_z_stage with MUL_LAT=2, DIV_LAT=32. Inputs are
//   driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_alu_z_stage;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic [4:0]  opcode;
   logic [4:0]  alu_op;
   logic [63:0] c_in;
   logic        busy;
   logic        z_valid;
   logic        z_ready;
   logic [31:0] zhi;
   logic [31:0] zlo;
   logic        zero_flag;
   logic        neg_flag;
   logic        op_illegal;

   int unsigned errors = 0;
   int unsigned checks = 0;

   alu_z_stage #(.MUL_LAT(2), .DIV_LAT(32)) dut (
      .clk        (clk),
      .clr        (clr),
      .start      (start),
      .opcode     (opcode),
      .alu_op     (alu_op),
      .c_in       (c_in),
      .busy       (busy),
      .z_valid    (z_valid),
      .z_ready    (z_ready),
      .zhi        (zhi),
      .zlo        (zlo),
      .zero_flag  (zero_flag),
      .neg_flag   (neg_flag),
      .op_illegal (op_illegal)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int unsigned seen;
      clr = 1'b1; start = 1'b0; opcode = '0; c_in = '0; z_ready = 1'b0;
      tick(); tick();
      clr = 1'b0;
      checks++;
      if ({alu_op, busy, z_valid, zhi, zlo, zero_flag, neg_flag, op_illegal} !== 75'd0) begin
         errors++;
         $display("FAIL reset_outputs: got alu_op=%b busy=%b v=%b zhi=%h zlo=%h z=%b n=%b ill=%b, expected all 0",
                  alu_op, busy, z_valid, zhi, zlo, zero_flag, neg_flag, op_illegal);
      end
      // DIV abandoned by clr at cycle 10
      opcode = 5'b10100; start = 1'b1; c_in = 64'h0000_0003_0000_0007;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL div_abort_busy: got %b expected 1", busy); end
      for (int i = 0; i < 9; i++) tick();
      clr = 1'b1;
      tick(); tick();
      clr = 1'b0;
      checks++;
      if ({alu_op, busy, z_valid, zhi, zlo, zero_flag, neg_flag, op_illegal} !== 75'd0) begin
         errors++;
         $display("FAIL abort_outputs: got alu_op=%b busy=%b v=%b zhi=%h zlo=%h, expected all 0",
                  alu_op, busy, z_valid, zhi, zlo);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (z_valid === 1'b1 || busy === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL abort_no_result: got %0d active cycles expected 0", seen); end
   endtask

   task automatic release_result(input string name);
      z_ready = 1'b1;
      tick();
      z_ready = 1'b0;
      checks++;
      if ({z_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL %s_release: got v=%b busy=%b expected 0 0", name, z_valid, busy);
      end
   endtask

   task automatic test_add();
      opcode = 5'b10001; start = 1'b1; c_in = 64'h0000_0001_0000_0005;
      tick();
      start = 1'b0;
      checks++;
      if ({busy, z_valid} !== 2'b10) begin
         errors++; $display("FAIL add_wait: got busy=%b v=%b expected 1 0", busy, z_valid);
      end
      tick();
      checks++;
      if ({z_valid, busy, alu_op} !== {2'b10, 5'b10001}) begin
         errors++; $display("FAIL add_valid: got v=%b busy=%b op=%b expected 1 0 10001", z_valid, busy, alu_op);
      end
      checks++;
      if ({zhi, zlo, zero_flag, neg_flag, op_illegal} !== {32'h0, 32'h5, 3'b000}) begin
         errors++;
         $display("FAIL add_result: got zhi=%h zlo=%h z=%b n=%b ill=%b expected 00000000 00000005 0 0 0",
                  zhi, zlo, zero_flag, neg_flag, op_illegal);
      end
      release_result("add");
   endtask

   task automatic test_mul();
      opcode = 5'b10011; start = 1'b1; c_in = 64'h0000_0000_0000_0001;
      tick();
      start = 1'b0;
      tick();
      c_in = 64'hFFFF_FFFF_FFFF_FFFE;
      checks++;
      if ({busy, z_valid} !== 2'b10) begin
         errors++; $display("FAIL mul_early: got busy=%b v=%b expected 1 0", busy, z_valid);
      end
      tick();
      c_in = '0;
      checks++;
      if (z_valid !== 1'b1) begin errors++; $display("FAIL mul_valid: got %b expected 1", z_valid); end
      checks++;
      if ({zhi, zlo, zero_flag, neg_flag, op_illegal} !== {32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'b010}) begin
         errors++;
         $display("FAIL mul_result: got zhi=%h zlo=%h z=%b n=%b ill=%b expected ffffffff fffffffe 0 1 0",
                  zhi, zlo, zero_flag, neg_flag, op_illegal);
      end
      release_result("mul");
   endtask

   // Leaves the DUT in HOLD for the handshake test.
   task automatic test_div();
      int unsigned busy_cycles;
      opcode = 5'b10100; start = 1'b1; c_in = 64'hAAAA_0000_BBBB_0000;
      tick();
      busy_cycles = (busy === 1'b1) ? 1 : 0;
      for (int i = 1; i <= 32; i++) begin
         c_in   = (i == 32) ? 64'h0000_0003_0000_0007 : {32'hAAAA_0000 + 32'(i), 32'h8000_0000 + 32'(i)};
         start  = (i == 5 || i == 20);
         opcode = 5'b00001;
         tick();
         if (busy === 1'b1) busy_cycles++;
      end
      start = 1'b0; c_in = 64'hFFFF_FFFF_FFFF_FFFF;
      checks++;
      if (busy_cycles != 32) begin errors++; $display("FAIL div_busy_len: got %0d expected 32", busy_cycles); end
      checks++;
      if ({z_valid, alu_op} !== {1'b1, 5'b10100}) begin
         errors++; $display("FAIL div_valid: got v=%b op=%b expected 1 10100", z_valid, alu_op);
      end
      checks++;
      if ({zhi, zlo, zero_flag, neg_flag, op_illegal} !== {32'h3, 32'h7, 3'b000}) begin
         errors++;
         $display("FAIL div_result: got zhi=%h zlo=%h z=%b n=%b ill=%b expected 00000003 00000007 0 0 0",
                  zhi, zlo, zero_flag, neg_flag, op_illegal);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned bad;
      bad = 0;
      start = 1'b1; opcode = 5'b00101; z_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if ({z_valid, busy, alu_op, zhi, zlo} !== {2'b10, 5'b10100, 32'h3, 32'h7}) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
      start = 1'b1; opcode = 5'b00000; c_in = '0; z_ready = 1'b1;
      tick();
      start = 1'b0; z_ready = 1'b0;
      checks++;
      if ({busy, z_valid, alu_op} !== {2'b10, 5'b00000}) begin
         errors++; $display("FAIL b2b_accept: got busy=%b v=%b op=%b expected 1 0 00000", busy, z_valid, alu_op);
      end
      tick();
      checks++;
      if ({z_valid, zhi, zlo, zero_flag, neg_flag, op_illegal} !== {1'b1, 64'd0, 3'b100}) begin
         errors++;
         $display("FAIL b2b_result: got v=%b zhi=%h zlo=%h z=%b n=%b ill=%b expected 1 0 0 1 0 0",
                  z_valid, zhi, zlo, zero_flag, neg_flag, op_illegal);
      end
      release_result("b2b");
   endtask

   task automatic test_illegal();
      opcode = 5'b01100; start = 1'b1; c_in = 64'hDEAD_BEEF_1234_5678;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if ({z_valid, zhi, zlo, zero_flag, neg_flag, op_illegal} !== {1'b1, 64'd0, 3'b101}) begin
         errors++;
         $display("FAIL illegal_result: got v=%b zhi=%h zlo=%h z=%b n=%b ill=%b expected 1 0 0 1 0 1",
                  z_valid, zhi, zlo, zero_flag, neg_flag, op_illegal);
      end
      release_result("illegal");
      // Defined single-cycle op with bit 31 set: flag from zlo, upper word dropped.
      opcode = 5'b00010; start = 1'b1; c_in = 64'h1234_5678_8000_0000;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if ({z_valid, zhi, zlo, zero_flag, neg_flag, op_illegal} !== {1'b1, 32'h0, 32'h8000_0000, 3'b010}) begin
         errors++;
         $display("FAIL neg_lo_result: got v=%b zhi=%h zlo=%h z=%b n=%b ill=%b expected 1 0 80000000 0 1 0",
                  z_valid, zhi, zlo, zero_flag, neg_flag, op_illegal);
      end
      release_result("neg_lo");
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_div();
      test_back_to_back();
      test_illegal();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
